// File: rtl/riscv_multicycle_datapath.sv
// Multicycle RV32I-subset core: datapath plus control FSM sharing one ready-handshaked memory port.
// Optional: define RISCV_MC_BRANCH_EXT_EN to add bne/blt/bge/bltu/bgeu to the branch unit.
module riscv_multicycle_datapath #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            illegal,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);
  localparam int RW = $clog2(NREGS);

  if (XLEN != 32) begin : g_bad_xlen
    $error("riscv_multicycle_datapath: XLEN must be 32");
  end
  if (NREGS != 32 && NREGS != 16) begin : g_bad_nregs
    $error("riscv_multicycle_datapath: NREGS must be 16 or 32");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_pc
    $error("riscv_multicycle_datapath: RESET_PC must be word aligned");
  end

  localparam logic [6:0] OP_LW = 7'h03, OP_SW = 7'h23, OP_R = 7'h33,
                         OP_I  = 7'h13, OP_BR = 7'h63, OP_JAL = 7'h6F;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  state_t state, nxt;
  logic [XLEN-1:0] ir, old_pc, a, b, alu_out, mdr;
  logic [XLEN-1:0] rf [NREGS];

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  logic [XLEN-1:0] rs1_v, rs2_v, ea, br_tgt, j_tgt;
  assign rs1_v  = (rs1 == 5'd0) ? '0 : rf[rs1[RW-1:0]];
  assign rs2_v  = (rs2 == 5'd0) ? '0 : rf[rs2[RW-1:0]];
  assign ea     = a + ((opc == OP_SW) ? imm_s : imm_i);
  assign br_tgt = old_pc + imm_b;
  assign j_tgt  = old_pc + imm_j;

  assign dbg_rdata = (dbg_raddr == 5'd0 || int'(dbg_raddr) >= NREGS) ? '0 : rf[dbg_raddr[RW-1:0]];

  // Branch unit: br_ok depends only on the instruction, take only on operands.
  logic take, br_ok;
  always_comb begin
    take  = 1'b0;
    br_ok = 1'b0;
    case (f3)
      3'b000: begin br_ok = 1'b1; take = (a == b); end
`ifdef RISCV_MC_BRANCH_EXT_EN
      3'b001: begin br_ok = 1'b1; take = (a != b); end
      3'b100: begin br_ok = 1'b1; take = ($signed(a) <  $signed(b)); end
      3'b101: begin br_ok = 1'b1; take = ($signed(a) >= $signed(b)); end
      3'b110: begin br_ok = 1'b1; take = (a <  b); end
      3'b111: begin br_ok = 1'b1; take = (a >= b); end
`endif
      default: ;
    endcase
  end

  logic op_ok, use_rd, use_rs1, use_rs2, reg_ok;
  always_comb begin
    op_ok   = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opc)
      OP_LW:  begin op_ok = (f3 == 3'b010); use_rd = 1'b1; use_rs1 = 1'b1; end
      OP_SW:  begin op_ok = (f3 == 3'b010); use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_R: begin
        op_ok = (f7 == 7'h00) ? (f3 != 3'b011)
              : (f7 == 7'h20) && (f3 == 3'b000 || f3 == 3'b101);
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_I: begin
        op_ok  = (f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b110 || f3 == 3'b111);
        use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_BR:  begin op_ok = br_ok; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_JAL: begin op_ok = 1'b1; use_rd = 1'b1; end
      default: ;
    endcase
  end
  // RV32E: any referenced register index >= 16 is undecodable.
  assign reg_ok = (NREGS == 32) || !((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]));

  logic [XLEN-1:0] b_op, alu_y;
  logic alt;
  assign b_op = (state == S_EXECI) ? imm_i : b;
  assign alt  = (opc == OP_R) && f7[5];
  always_comb begin
    alu_y = '0;
    case (f3)
      3'b000:  alu_y = alt ? a - b_op : a + b_op;
      3'b001:  alu_y = a << b_op[4:0];
      3'b010:  alu_y = {31'b0, $signed(a) < $signed(b_op)};
      3'b100:  alu_y = a ^ b_op;
      3'b101:  alu_y = alt ? $unsigned($signed(a) >>> b_op[4:0]) : a >> b_op[4:0];
      3'b110:  alu_y = a | b_op;
      3'b111:  alu_y = a & b_op;
      default: alu_y = a + b_op;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_RST;
    else       state <= nxt;
  end

  always_comb begin
    nxt       = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = alu_out;
    retire    = 1'b0;
    case (state)
      S_RST:   nxt = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        if (!op_ok || !reg_ok) nxt = S_TRAP;
        else begin
          case (opc)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_R:         nxt = S_EXECR;
            OP_I:         nxt = S_EXECI;
            OP_BR:        nxt = S_BRANCH;
            default:      nxt = S_JAL;
          endcase
        end
      end
      S_MEMADR: begin
        if (ea[1:0] != 2'b00) nxt = S_TRAP;
        else                  nxt = (opc == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        if (mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin retire = 1'b1; nxt = S_FETCH; end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin retire = 1'b1; nxt = S_FETCH; end
      end
      S_EXECR, S_EXECI: nxt = S_ALUWB;
      S_ALUWB: begin retire = 1'b1; nxt = S_FETCH; end
      S_BRANCH: begin
        if (take && br_tgt[1:0] != 2'b00) nxt = S_TRAP;
        else begin retire = 1'b1; nxt = S_FETCH; end
      end
      S_JAL: begin
        if (j_tgt[1:0] != 2'b00) nxt = S_TRAP;
        else begin retire = 1'b1; nxt = S_FETCH; end
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_RST;
    endcase
  end

  assign mem_wdata = b;
  assign illegal   = (state == S_TRAP);

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir     <= mem_rdata;
          old_pc <= pc;
          pc     <= pc + 32'd4;
        end
        S_DECODE: begin a <= rs1_v; b <= rs2_v; end
        S_MEMADR: alu_out <= ea;
        S_MEMRD:  if (mem_ready) mdr <= mem_rdata;
        S_EXECR, S_EXECI: alu_out <= alu_y;
        S_BRANCH: if (take && br_tgt[1:0] == 2'b00) pc <= br_tgt;
        S_JAL:    if (j_tgt[1:0] == 2'b00) pc <= j_tgt;
        default: ;
      endcase
    end
  end

  logic            rf_we;
  logic [XLEN-1:0] rf_wd;
  always_comb begin
    rf_we = 1'b0;
    rf_wd = alu_out;
    case (state)
      S_ALUWB: rf_we = 1'b1;
      S_MEMWB: begin rf_we = 1'b1; rf_wd = mdr; end
      S_JAL:   begin rf_we = (j_tgt[1:0] == 2'b00); rf_wd = pc; end
      default: ;
    endcase
  end

  // No reset on the register file; a reset edge suppresses any pending writeback.
  always_ff @(posedge clk) begin
    if (!reset && rf_we && rd != 5'd0) rf[rd[RW-1:0]] <= rf_wd;
  end
endmodule

// File: tb/tb_riscv_multicycle_datapath.sv
// Directed bench for riscv_multicycle_datapath: table-driven program plus handshake/reset/trap sequences.
module tb_riscv_multicycle_datapath;
  logic        clk = 1'b0, reset = 1'b1, rdy = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, dbg_rdata;
  logic [4:0]  dbg_raddr = 5'd0;
  logic [31:0] mem [256];

  riscv_multicycle_datapath dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .retire(retire), .illegal(illegal), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;
  assign mem_ready = rdy;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_req && mem_we && mem_ready) mem[mem_addr[9:2]] <= mem_wdata;

  localparam logic [6:0] OP_LW = 7'h03, OP_I = 7'h13;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    int          cyc;   // cycles from previous retire (first entry includes the RST cycle)
    logic [31:0] epc;
    bit          is_mem;
    int          idx;   // register index, or memory word index when is_mem
    logic [31:0] val;
  } vec_t;
  vec_t tv[$];

  int checks = 0, errors = 0;
  int cnt, hold, rets, dreq;
  bit seen;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] ad, input logic [31:0] ins, input int c, input logic [31:0] p,
                     input bit m, input int i, input logic [31:0] v);
    vec_t e;
    e = '{ad, ins, c, p, m, i, v};
    tv.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    rdy   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'b0, mem_req}, 32'h0);
    check("rst_we", {31'b0, mem_we}, 32'h0);
    check("rst_retire", {31'b0, retire}, 32'h0);
    check("rst_illegal", {31'b0, illegal}, 32'h0);
    reset = 1'b0;
  endtask

  task automatic read_reg(input int r, output logic [31:0] v);
    dbg_raddr = r[4:0];
    #1;
    v = dbg_rdata;
  endtask

  // addi x1,x0,1 at 0, i1 at 4, an undecodable word at 0xC; counts retires and non-fetch requests.
  task automatic run_prog2(input logic [31:0] i1, output int nret, output int nreq);
    clear_mem();
    mem[0] <= enc_i(12'd1, 5'd0, 3'b000, 5'd1, OP_I);
    mem[1] <= i1;
    mem[3] <= 32'h0000007F;
    reset_dut();
    nret = 0;
    nreq = 0;
    repeat (25) begin
      @(negedge clk);
      if (retire) nret++;
      if (mem_req && (mem_we || (mem_addr != 32'h0 && mem_addr != 32'h4 && mem_addr != 32'hC))) nreq++;
    end
  endtask

  initial begin
    logic [31:0] v;
    add(32'h00, enc_i(12'd5,   5'd0, 3'b000, 5'd1,  OP_I),       5, 32'h04, 0, 1,  32'd5);
    add(32'h04, enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2),         4, 32'h08, 0, 2,  32'd10);
    add(32'h08, enc_i(12'hFFD, 5'd0, 3'b000, 5'd3,  OP_I),       4, 32'h0C, 0, 3,  32'hFFFFFFFD);
    add(32'h0C, enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4),         4, 32'h10, 0, 4,  32'hFFFFFFFB);
    add(32'h10, enc_r(7'h00, 5'd3, 5'd2, 3'b111, 5'd5),         4, 32'h14, 0, 5,  32'h8);
    add(32'h14, enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd6),         4, 32'h18, 0, 6,  32'hF);
    add(32'h18, enc_r(7'h00, 5'd1, 5'd3, 3'b100, 5'd7),         4, 32'h1C, 0, 7,  32'hFFFFFFF8);
    add(32'h1C, enc_r(7'h00, 5'd1, 5'd3, 3'b010, 5'd8),         4, 32'h20, 0, 8,  32'h1);
    add(32'h20, enc_r(7'h00, 5'd1, 5'd1, 3'b001, 5'd9),         4, 32'h24, 0, 9,  32'hA0);
    add(32'h24, enc_r(7'h00, 5'd1, 5'd3, 3'b101, 5'd10),        4, 32'h28, 0, 10, 32'h07FFFFFF);
    add(32'h28, enc_r(7'h20, 5'd1, 5'd3, 3'b101, 5'd11),        4, 32'h2C, 0, 11, 32'hFFFFFFFF);
    add(32'h2C, enc_i(12'h0F0, 5'd3, 3'b111, 5'd12, OP_I),       4, 32'h30, 0, 12, 32'hF0);
    add(32'h30, enc_i(12'hFF0, 5'd1, 3'b110, 5'd13, OP_I),       4, 32'h34, 0, 13, 32'hFFFFFFF5);
    add(32'h34, enc_i(12'h7FF, 5'd1, 3'b100, 5'd14, OP_I),       4, 32'h38, 0, 14, 32'h7FA);
    add(32'h38, enc_i(12'hFFF, 5'd1, 3'b010, 5'd15, OP_I),       4, 32'h3C, 0, 15, 32'h0);
    add(32'h3C, enc_s(12'h080, 5'd2, 5'd0),                     4, 32'h40, 1, 32, 32'hA);
    add(32'h40, enc_i(12'h080, 5'd0, 3'b010, 5'd16, OP_LW),      5, 32'h44, 0, 16, 32'hA);
    add(32'h44, enc_i(12'h084, 5'd0, 3'b010, 5'd17, OP_LW),      5, 32'h48, 0, 17, 32'hDEADBEEF);
    add(32'h48, enc_b(13'd8, 5'd1, 5'd1, 3'b000),                3, 32'h50, 0, 1,  32'd5);
    add(32'h50, enc_b(13'd8, 5'd2, 5'd1, 3'b000),                3, 32'h54, 0, 2,  32'd10);
    add(32'h54, enc_j(21'd12, 5'd19),                            3, 32'h60, 0, 19, 32'h58);
    add(32'h60, enc_i(12'd7, 5'd1, 3'b000, 5'd0, OP_I),          4, 32'h64, 0, 0,  32'h0);
    add(32'h64, enc_b(13'h1FF8, 5'd0, 5'd0, 3'b000),             3, 32'h5C, 0, 0,  32'h0);
    add(32'h5C, enc_j(21'd12, 5'd22),                            3, 32'h68, 0, 22, 32'h60);
    add(32'h68, enc_r(7'h00, 5'd2, 5'd3, 3'b001, 5'd23),        4, 32'h6C, 0, 23, 32'hFFFFF400);

    clear_mem();
    foreach (tv[k]) mem[tv[k].addr[9:2]] <= tv[k].instr;
    mem[33] <= 32'hDEADBEEF;
    reset_dut();
    foreach (tv[k]) begin
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 40) begin
        @(negedge clk);
        cnt++;
        if (retire) seen = 1'b1;
      end
      check($sformatf("cyc[%0d]", k), cnt, tv[k].cyc);
      @(posedge clk);
      #1;
      check($sformatf("pc[%0d]", k), pc, tv[k].epc);
      if (tv[k].is_mem) check($sformatf("mem[%0d]", k), mem[tv[k].idx], tv[k].val);
      else begin
        read_reg(tv[k].idx, v);
        check($sformatf("reg[%0d]", k), v, tv[k].val);
      end
    end
    check("no_illegal_prog", {31'b0, illegal}, 32'h0);

    // lw with ready held low for three MEMRD cycles
    clear_mem();
    mem[0] <= enc_i(12'd4, 5'd0, 3'b010, 5'd3, OP_LW);
    mem[1] <= 32'hDEADBEEF;
    reset_dut();
    cnt = 0; hold = 0; seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (mem_req && !mem_we && mem_addr == 32'h4) begin
        hold++;
        rdy = (hold >= 4);
      end
      if (retire) seen = 1'b1;
    end
    rdy = 1'b1;
    check("lw_stall_cycles", cnt, 9);
    check("lw_req_held", hold, 4);
    @(posedge clk);
    #1;
    read_reg(3, v);
    check("lw_stall_x3", v, 32'hDEADBEEF);
    check("lw_stall_pc", pc, 32'h4);

    // reset while a store waits for ready
    clear_mem();
    mem[0] <= enc_i(12'h055, 5'd0, 3'b000, 5'd6, OP_I);
    mem[1] <= enc_s(12'h080, 5'd6, 5'd0);
    reset_dut();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) seen = 1'b1;
    end
    check("sw_reached", {31'b0, seen}, 32'h1);
    rdy = 1'b0;
    @(negedge clk);
    check("sw_hold_req", {31'b0, mem_req & mem_we}, 32'h1);
    check("sw_hold_addr", mem_addr, 32'h80);
    check("sw_hold_wdata", mem_wdata, 32'h55);
    check("sw_hold_retire", {31'b0, retire}, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("sw_abort_req", {31'b0, mem_req}, 32'h0);
    check("sw_abort_pc", pc, 32'h0);
    check("sw_abort_mem", mem[32], 32'h0);
    read_reg(6, v);
    check("sw_abort_x6", v, 32'h55);
    rdy = 1'b1;

    // traps: each case retires only the leading addi and parks with pc at 8
    run_prog2(32'h0000007F, rets, dreq);
    check("trap7f_retire", rets, 1);
    check("trap7f_illegal", {31'b0, illegal}, 32'h1);
    check("trap7f_req", {31'b0, mem_req}, 32'h0);
    check("trap7f_pc", pc, 32'h8);
    run_prog2(enc_i(12'd2, 5'd0, 3'b010, 5'd7, OP_LW), rets, dreq);
    check("misal_lw_retire", rets, 1);
    check("misal_lw_noreq", dreq, 0);
    check("misal_lw_illegal", {31'b0, illegal}, 32'h1);
    run_prog2(enc_b(13'd2, 5'd0, 5'd0, 3'b000), rets, dreq);
    check("misal_br_retire", rets, 1);
    check("misal_br_pc", pc, 32'h8);
    check("misal_br_illegal", {31'b0, illegal}, 32'h1);
    run_prog2(enc_r(7'h00, 5'd1, 5'd1, 3'b011, 5'd4), rets, dreq);
    check("sltu_trap_retire", rets, 1);
    check("sltu_trap_illegal", {31'b0, illegal}, 32'h1);
    run_prog2(enc_b(13'd8, 5'd0, 5'd1, 3'b001), rets, dreq);
`ifdef RISCV_MC_BRANCH_EXT_EN
    check("bne_retire", rets, 2);
    check("bne_pc", pc, 32'h10);
`else
    check("bne_retire", rets, 1);
    check("bne_pc", pc, 32'h8);
`endif
    check("bne_illegal", {31'b0, illegal}, 32'h1);
    reset_dut();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
